// File: rtl/ama_riscv_fetch.sv
// RISC-V IF stage: owns the PC, issues imem requests over valid/ready, and hands inst/PC pairs to decode.
// Define FETCH_PREFETCH_EN for the 2-deep prefetch variant; the default build is the one-outstanding FSM.
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h4000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_out,
  input  logic        flush_dec,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_dec,
  output logic [31:0] pc_dec,
  output logic        inst_valid_dec
);
  logic        redirect;
  logic [31:0] target;
  logic        unused;

  assign redirect = pc_we & (pc_sel == 2'd1);
  assign target   = {alu_out[31:2], 2'b00};
  assign unused   = &{1'b0, alu_out[1:0]};

`ifdef FETCH_PREFETCH_EN
  logic [1:0]  outs, cnt, dcnt, outs_n, cnt_n, dcnt_n;
  logic        stale, stale_n, acc, rsp, drop_now, push, pop, issue;
  logic        head, tail, head_n, tail_n, req_valid_n;
  logic [31:0] pc, pc_n, pc_base, req_addr, req_addr_n, rsp_pc, rsp_pc_n;
  logic [31:0] fifo_inst [2];
  logic [31:0] fifo_pc   [2];

  assign acc            = imem_req_valid & imem_req_ready;
  assign rsp            = imem_rsp_valid & imem_rsp_ready;
  assign imem_rsp_ready = (outs != 2'd0);
  assign imem_req_addr  = req_addr;
  assign inst_valid_dec = (cnt != 2'd0);
  assign inst_dec       = inst_valid_dec ? fifo_inst[head] : NOP_INST;
  assign pc_dec         = inst_valid_dec ? fifo_pc[head]   : rsp_pc;

  always_comb begin
    drop_now = rsp & (dcnt != 2'd0);
    push     = rsp & ~drop_now & ~redirect;
    pop      = (pc_we | flush_dec) & inst_valid_dec;
    outs_n   = outs + {1'b0, acc} - {1'b0, rsp};
    dcnt_n   = dcnt - {1'b0, drop_now};
    if (acc & stale) dcnt_n = dcnt_n + 2'd1;
    cnt_n    = cnt + {1'b0, push} - {1'b0, pop};
    head_n   = head ^ pop;
    tail_n   = tail ^ push;
    stale_n  = stale & ~acc;
    rsp_pc_n = push ? rsp_pc + 32'd4 : rsp_pc;
    pc_base  = pc;
    // Everything already in flight is off-path; a request still waiting for ready is marked stale.
    if (redirect) begin
      cnt_n    = 2'd0;
      head_n   = 1'b0;
      tail_n   = 1'b0;
      dcnt_n   = outs_n;
      stale_n  = imem_req_valid & ~acc;
      rsp_pc_n = target;
      pc_base  = target;
    end
    issue = 1'b0;
    if (imem_req_valid & ~acc) begin
      req_valid_n = 1'b1;
      req_addr_n  = req_addr;
      pc_n        = pc_base;
    end else begin
      issue       = ({1'b0, outs_n} + {1'b0, cnt_n}) < 3'd2;
      req_valid_n = issue;
      req_addr_n  = issue ? pc_base : req_addr;
      pc_n        = issue ? pc_base + 32'd4 : pc_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs <= 2'd0; cnt <= 2'd0; dcnt <= 2'd0; stale <= 1'b0;
      head <= 1'b0; tail <= 1'b0; imem_req_valid <= 1'b0;
      pc <= RESET_VECTOR; req_addr <= RESET_VECTOR; rsp_pc <= RESET_VECTOR;
    end else begin
      outs <= outs_n; cnt <= cnt_n; dcnt <= dcnt_n; stale <= stale_n;
      head <= head_n; tail <= tail_n; imem_req_valid <= req_valid_n;
      pc <= pc_n; req_addr <= req_addr_n; rsp_pc <= rsp_pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[tail] <= imem_rsp_data;
      fifo_pc[tail]   <= rsp_pc;
    end
  end
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t      state;
  logic [31:0] pc, redir_pend;
  logic        drop, redir;

  assign imem_req_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_VECTOR;
      redir_pend     <= RESET_VECTOR;
      drop           <= 1'b0;
      redir          <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_rsp_ready <= 1'b0;
      inst_dec       <= NOP_INST;
      pc_dec         <= RESET_VECTOR;
      inst_valid_dec <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req_valid) begin
            imem_req_valid <= 1'b1;
            if (redirect) pc <= target;
          end else begin
            // Address is already exposed and must stay put; remember the target instead.
            if (redirect) begin
              redir      <= 1'b1;
              redir_pend <= target;
            end
            if (imem_req_ready) begin
              imem_req_valid <= 1'b0;
              imem_rsp_ready <= 1'b1;
              drop           <= redir | redirect;
              redir          <= 1'b0;
              state          <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (redirect) begin
            drop       <= 1'b1;
            redir_pend <= target;
          end
          if (imem_rsp_valid) begin
            imem_rsp_ready <= 1'b0;
            drop           <= 1'b0;
            if (drop || redirect) begin
              pc             <= redirect ? target : redir_pend;
              imem_req_valid <= 1'b1;
              state          <= S_REQ;
            end else begin
              inst_dec       <= imem_rsp_data;
              pc_dec         <= pc;
              inst_valid_dec <= 1'b1;
              state          <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (pc_we) begin
            pc             <= redirect ? target : pc + 32'd4;
            inst_dec       <= NOP_INST;
            inst_valid_dec <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
      if (flush_dec) begin
        inst_dec       <= NOP_INST;
        inst_valid_dec <= 1'b0;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  rsp_only_when_ready: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> imem_rsp_ready);
`endif
endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch (default build): reset, in-order fetch, stall, redirect/drop,
// backpressure, PC wrap, pc_sel=2, flush and mid-transaction async reset.
module tb_ama_riscv_fetch;
  localparam logic [31:0] RV  = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1, pc_we = 1'b0, flush_dec = 1'b0;
  logic        imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] alu_out = '0, imem_rsp_data = '0;
  logic        imem_req_valid, imem_rsp_ready, inst_valid_dec;
  logic [31:0] imem_req_addr, inst_dec, pc_dec;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  ama_riscv_fetch dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_sel(pc_sel), .alu_out(alu_out),
    .flush_dec(flush_dec), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .inst_dec(inst_dec), .pc_dec(pc_dec), .inst_valid_dec(inst_valid_dec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request currently valid with ready=1: accept it, then return data one cycle later.
  task automatic fetch_one(input logic [31:0] data);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic advance(input logic [1:0] sel, input logic [31:0] tgt);
    pc_we = 1'b1; pc_sel = sel; alu_out = tgt;
    step();
    pc_we = 1'b0; pc_sel = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    check("rst_inst_dec", inst_dec, NOP);
    check("rst_pc_dec", pc_dec, RV);
    check("rst_valid", 32'(inst_valid_dec), 32'd0);

    rst = 1'b0;
    step();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_addr", imem_req_addr, RV);
    step();
    check("acc_req_valid", 32'(imem_req_valid), 32'd0);
    check("acc_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    check("acc_no_inst", 32'(inst_valid_dec), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    check("i0_valid", 32'(inst_valid_dec), 32'd1);
    check("i0_inst", inst_dec, 32'h0010_0093);
    check("i0_pc", pc_dec, RV);

    advance(2'd0, 32'h0);
    check("seq1_addr", imem_req_addr, 32'h4000_0004);
    check("seq1_req_valid", 32'(imem_req_valid), 32'd1);
    check("seq1_consumed", 32'(inst_valid_dec), 32'd0);
    fetch_one(32'h0020_0113);
    check("i1_inst", inst_dec, 32'h0020_0113);
    check("i1_pc", pc_dec, 32'h4000_0004);

    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_inst", inst_dec, 32'h0020_0113);
      check("stall_pc", pc_dec, 32'h4000_0004);
      check("stall_valid", 32'(inst_valid_dec), 32'd1);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end

    advance(2'd0, 32'h0);
    check("seq2_addr", imem_req_addr, 32'h4000_0008);
    fetch_one(32'h0030_0193);
    check("i2_inst", inst_dec, 32'h0030_0193);
    check("i2_pc", pc_dec, 32'h4000_0008);

    // Redirect while the request for 0x4000_000C is outstanding.
    advance(2'd0, 32'h0);
    step();
    check("wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    advance(2'd1, 32'h4000_0103);
    check("redir_wait_valid", 32'(inst_valid_dec), 32'd0);
    check("redir_still_wait", 32'(imem_rsp_ready), 32'd1);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("stale_valid", 32'(inst_valid_dec), 32'd0);
    check("stale_inst", inst_dec, NOP);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_addr", imem_req_addr, 32'h4000_0100);

    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_addr", imem_req_addr, 32'h4000_0100);
      check("bp_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    end
    imem_req_ready = 1'b1;
    step();
    check("bp_accepted", 32'(imem_req_valid), 32'd0);
    check("bp_rsp_ready_after", 32'(imem_rsp_ready), 32'd1);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0213;
    step();
    imem_rsp_valid = 1'b0;
    check("i3_inst", inst_dec, 32'h0040_0213);
    check("i3_pc", pc_dec, 32'h4000_0100);
    check("i3_valid", 32'(inst_valid_dec), 32'd1);

    advance(2'd1, 32'hFFFF_FFFC);
    check("wrap_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_redir_valid", 32'(inst_valid_dec), 32'd0);
    fetch_one(32'h0050_0293);
    check("i4_pc", pc_dec, 32'hFFFF_FFFC);
    check("i4_inst", inst_dec, 32'h0050_0293);
    advance(2'd0, 32'h0);
    check("wrap_addr", imem_req_addr, 32'h0000_0000);
    fetch_one(32'h0060_0313);
    check("i5_pc", pc_dec, 32'h0000_0000);

    flush_dec = 1'b1;
    step();
    flush_dec = 1'b0;
    check("flush_valid", 32'(inst_valid_dec), 32'd0);
    check("flush_inst", inst_dec, NOP);
    check("flush_pc", pc_dec, 32'h0000_0000);
    check("flush_no_req", 32'(imem_req_valid), 32'd0);
    advance(2'd2, 32'h1234_5678);
    check("sel2_addr", imem_req_addr, 32'h0000_0004);

    // Async reset in WAIT; the response shows up while reset is held.
    step();
    check("pre_rst_wait", 32'(imem_rsp_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req_valid", 32'(imem_req_valid), 32'd0);
    check("arst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    check("arst_addr", imem_req_addr, RV);
    check("arst_pc_dec", pc_dec, RV);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rel_req_valid", 32'(imem_req_valid), 32'd1);
    check("rel_addr", imem_req_addr, RV);
    check("rel_inst", inst_dec, NOP);
    check("rel_valid", 32'(inst_valid_dec), 32'd0);
    fetch_one(32'h0070_0393);
    check("i6_inst", inst_dec, 32'h0070_0393);
    check("i6_pc", pc_dec, RV);
    check("i6_valid", 32'(inst_valid_dec), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
